// File: rtl/color_cfg_master.sv
// color_cfg_master: command-byte FIFO draining into a four-phase write handshake toward a color register file.
// Optional ack timeout with sticky err flag is enabled by defining COLOR_CFG_TIMEOUT_EN.
module color_cfg_master #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] cmd_byte,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   output logic [3:0] address,
   output logic [3:0] data,
   output logic       valid,
   input  logic       ack,
   output logic       busy,
   output logic       err,
   input  logic       err_clr
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_REL  = 2'd2;

   logic [7:0]       mem_q [0:FIFO_DEPTH-1];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [1:0]       state_q, state_d;
   logic [3:0]       address_q, address_d;
   logic [3:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             push, pop;
   logic [7:0]       head;
   logic             tmo_hit;
   logic             err_set;

   // Ready depends only on the registered count, so a full FIFO refuses a byte even on a popping cycle.
   assign cmd_ready = (count_q < CNT_W'(FIFO_DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state_q == ST_IDLE) && (count_q != '0);
   assign head      = mem_q[rd_ptr_q];

   // NOTE: every _d gets its default first, so no branch leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      address_d = address_q;
      data_d    = data_q;
      valid_d   = valid_q;
      err_set   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               address_d = head[7:4];
               data_d    = head[3:0];
               valid_d   = 1'b1;
               state_d   = ST_REQ;
            end
         end
         ST_REQ: begin
            if (ack) begin
               valid_d = 1'b0;
               state_d = ST_REL;
            end else if (tmo_hit) begin
               valid_d = 1'b0;
               err_set = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_REL: begin
            if (!ack) begin
               state_d = ST_IDLE;
            end else if (tmo_hit) begin
               err_set = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         state_q   <= ST_IDLE;
         address_q <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         state_q   <= state_d;
         address_q <= address_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
      end
   end

   // NOTE: the byte array is not reset; count and pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= cmd_byte;
   end

`ifdef COLOR_CFG_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;

   // Counter restarts on every state change and only advances while parked in REQ or REL.
   assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      tmo_d = '0;
      if ((state_d == state_q) && (state_q != ST_IDLE)) tmo_d = tmo_q + TMO_W'(1);
      err_d = err_q;
      if (err_clr) err_d = 1'b0;
      if (err_set) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   logic unused_err_inputs;

   assign tmo_hit           = 1'b0;
   assign err               = 1'b0;
   assign unused_err_inputs = err_clr | err_set;
`endif

   assign address = address_q;
   assign data    = data_q;
   assign valid   = valid_q;
   assign busy    = (count_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_color_cfg_master.sv
// Testbench for color_cfg_master: directed vector table, multi-cycle corner sequences and a randomized run
// checked against a queue-based reference model. Define COLOR_CFG_TIMEOUT_EN for bench and RTL to cover the timeout.
module tb_color_cfg_master;

   localparam int DEPTH = 4;
   localparam int TMO   = 8;

   logic       clk = 1'b0;
   logic       rst, cmd_valid, ack, err_clr;
   logic [7:0] cmd_byte;
   logic       cmd_ready, valid, busy, err;
   logic [3:0] address, data;

   color_cfg_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_byte  (cmd_byte),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .address   (address),
      .data      (data),
      .valid     (valid),
      .ack       (ack),
      .busy      (busy),
      .err       (err),
      .err_clr   (err_clr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a byte queue, the word currently on the bus, and whether it still awaits ack.
   logic [7:0] m_q[$];
   bit         m_hs;
   bit         m_req;
   bit         m_err;
   logic [3:0] m_addr, m_data;
   int         m_wait;

   task automatic model_reset();
      m_q.delete();
      m_hs   = 0;
      m_req  = 0;
      m_err  = 0;
      m_addr = 4'h0;
      m_data = 4'h0;
      m_wait = 0;
   endtask

   task automatic model_step(input logic r, input logic cv, input logic [7:0] cb, input logic a, input logic ec);
      bit         accept;
      bit         set_err;
      logic [7:0] b;
      set_err = 0;
      if (!r) begin
         model_reset();
         return;
      end
      accept = cv && (m_q.size() < DEPTH);
      if (!m_hs) begin
         if (m_q.size() > 0) begin
            b      = m_q.pop_front();
            m_addr = b[7:4];
            m_data = b[3:0];
            m_hs   = 1;
            m_req  = 1;
            m_wait = 0;
         end
      end else if (m_req) begin
         if (a) begin
            m_req  = 0;
            m_wait = 0;
         end else begin
            m_wait++;
`ifdef COLOR_CFG_TIMEOUT_EN
            if (m_wait == TMO) begin
               m_hs    = 0;
               m_req   = 0;
               set_err = 1;
            end
`endif
         end
      end else begin
         if (!a) begin
            m_hs = 0;
         end else begin
            m_wait++;
`ifdef COLOR_CFG_TIMEOUT_EN
            if (m_wait == TMO) begin
               m_hs    = 0;
               set_err = 1;
            end
`endif
         end
      end
      if (accept) m_q.push_back(cb);
`ifdef COLOR_CFG_TIMEOUT_EN
      if (set_err) m_err = 1;
      else if (ec) m_err = 0;
`else
      if (ec) m_err = 0;
`endif
   endtask

   // Log of issued words, one entry per rising edge of valid.
   logic [7:0] wr_log[$];
   logic [7:0] exp_w[$];
   bit         prev_v = 0;
   int         log_base;

   // One clock: drive inputs, let the edge happen, advance the model, then compare at the falling edge.
   task automatic cycle(input logic r, input logic cv, input logic [7:0] cb, input logic a, input logic ec);
      rst = r; cmd_valid = cv; cmd_byte = cb; ack = a; err_clr = ec;
      @(posedge clk);
      model_step(r, cv, cb, a, ec);
      @(negedge clk);
      check("ready", cmd_ready, m_q.size() < DEPTH);
      check("valid", valid, m_req);
      check("address", address, m_addr);
      check("data", data, m_data);
      check("busy", busy, (m_q.size() != 0) || m_hs);
      check("err", err, m_err);
      if (valid === 1'b1 && !prev_v) wr_log.push_back({address, data});
      prev_v = (valid === 1'b1);
   endtask

   // Acknowledging responder: raises ack once valid has been seen for more than 'delay' cycles.
   task automatic drain(input int delay);
      int   hi;
      bit   done;
      logic a;
      hi   = 0;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         hi = (valid === 1'b1) ? hi + 1 : 0;
         a  = (valid === 1'b1) && (hi > delay);
         cycle(1'b1, 1'b0, 8'h00, a, 1'b0);
         done = (m_q.size() == 0) && !m_hs;
      end
      check("drain_done", done, 1'b1);
   endtask

   task automatic check_tail(input string name);
      check({name, "_count"}, wr_log.size() - log_base, exp_w.size());
      for (int i = 0; i < exp_w.size(); i++)
         if (log_base + i < wr_log.size()) check(name, wr_log[log_base + i], exp_w[i]);
   endtask

   typedef struct {
      logic       cv;
      logic [7:0] cb;
      logic       ack;
      logic       e_ready;
      logic       e_valid;
      logic [3:0] e_addr;
      logic [3:0] e_data;
      logic       e_busy;
   } vec_t;

   vec_t vt[17];

   initial begin
      logic       a_rand;
      logic [7:0] fill_b[5];
      logic       fill_rdy[5];
      int         n_before;

      // Single write with a two-cycle ack delay, then two back-to-back words with immediate ack,
      // then ack held high across IDLE.
      vt[0]  = '{1'b1, 8'h35, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1};
      vt[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'h3, 4'h5, 1'b1};
      vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'h3, 4'h5, 1'b1};
      vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'h3, 4'h5, 1'b1};
      vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'h3, 4'h5, 1'b0};
      vt[5]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 4'h3, 4'h5, 1'b1};
      vt[6]  = '{1'b1, 8'hB2, 1'b0, 1'b1, 1'b1, 4'hA, 4'h1, 1'b1};
      vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'hA, 4'h1, 1'b1};
      vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'hA, 4'h1, 1'b1};
      vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'hB, 4'h2, 1'b1};
      vt[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'hB, 4'h2, 1'b1};
      vt[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'hB, 4'h2, 1'b0};
      vt[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'hB, 4'h2, 1'b0};
      vt[13] = '{1'b1, 8'hC4, 1'b1, 1'b1, 1'b0, 4'hB, 4'h2, 1'b1};
      vt[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'hC, 4'h4, 1'b1};
      vt[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'hC, 4'h4, 1'b1};
      vt[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'hC, 4'h4, 1'b0};

      rst = 1'b0; cmd_valid = 1'b0; cmd_byte = 8'h00; ack = 1'b0; err_clr = 1'b0;
      model_reset();

      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      check("rst_ready", cmd_ready, 1'b1);
      check("rst_valid", valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_address", address, 4'h0);
      check("rst_data", data, 4'h0);

      log_base = wr_log.size();
      for (int i = 0; i < 17; i++) begin
         cycle(1'b1, vt[i].cv, vt[i].cb, vt[i].ack, 1'b0);
         check("tbl_ready", cmd_ready, vt[i].e_ready);
         check("tbl_valid", valid, vt[i].e_valid);
         check("tbl_address", address, vt[i].e_addr);
         check("tbl_data", data, vt[i].e_data);
         check("tbl_busy", busy, vt[i].e_busy);
      end
      exp_w = '{8'h35, 8'hA1, 8'hB2, 8'hC4};
      check_tail("tbl_writes");

      // Full FIFO behind a stalled word: fifth byte is dropped, the rest issue in order.
      fill_b   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      fill_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      log_base = wr_log.size();
      cycle(1'b1, 1'b1, 8'h0F, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, 1'b1, fill_b[k], 1'b0, 1'b0);
         check("full_ready", cmd_ready, fill_rdy[k]);
      end
      drain(0);
      exp_w = '{8'h0F, 8'h11, 8'h22, 8'h33, 8'h44};
      check_tail("full_order");

      // Push and pop on the same edge at count 2, then refill to full across the pointer wrap.
      log_base = wr_log.size();
      cycle(1'b1, 1'b1, 8'h90, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 8'hA0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 8'hB0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 8'hC0, 1'b0, 1'b0);
      check("pp_valid", valid, 1'b1);
      check("pp_address", address, 4'hA);
      check("pp_ready", cmd_ready, 1'b1);
      cycle(1'b1, 1'b1, 8'hD0, 1'b0, 1'b0);
      check("pp_ready3", cmd_ready, 1'b1);
      cycle(1'b1, 1'b1, 8'hE0, 1'b0, 1'b0);
      check("pp_ready4", cmd_ready, 1'b0);
      drain(0);
      exp_w = '{8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0};
      check_tail("pp_order");

`ifdef COLOR_CFG_TIMEOUT_EN
      begin
         int hi_n;
         cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
         cycle(1'b1, 1'b1, 8'h7C, 1'b0, 1'b0);
         cycle(1'b1, 1'b1, 8'h8D, 1'b0, 1'b0);
         hi_n = 0;
         for (int i = 0; i < 40 && valid === 1'b1; i++) begin
            hi_n++;
            cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
         end
         check("tmo_valid_cycles", hi_n, TMO);
         check("tmo_err", err, 1'b1);
         check("tmo_address_hold", address, 4'h7);
         cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
         check("tmo_next_valid", valid, 1'b1);
         check("tmo_next_address", address, 4'h8);
         check("tmo_next_data", data, 4'hD);
         drain(0);
         check("tmo_err_sticky", err, 1'b1);
         cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
         check("tmo_err_clr", err, 1'b0);
      end
`else
      cycle(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'(i % 2));
      check("notmo_valid_held", valid, 1'b1);
      check("notmo_err", err, 1'b0);
      drain(0);
`endif

      // Reset in the middle of a handshake with bytes still queued.
      cycle(1'b1, 1'b1, 8'h61, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 8'h62, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 8'h63, 1'b0, 1'b0);
      check("prerst_valid", valid, 1'b1);
      n_before = wr_log.size();
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      check("midrst_valid", valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_ready", cmd_ready, 1'b1);
      check("midrst_address", address, 4'h0);
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      check("midrst_no_writes", wr_log.size(), n_before);
      check("midrst_idle_busy", busy, 1'b0);

      // Randomized traffic against the model.
      a_rand = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) a_rand = ~a_rand;
         cycle(($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)), 8'($urandom),
               a_rand, ($urandom_range(0, 15) == 0));
      end
      drain(1);
      check("final_busy", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/color_cfg_master.md
COLOR_CFG_MASTER -- requirements
Module: color_cfg_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning command byte FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max cycles waiting for ack in either handshake phase.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cmd_byte  input  8  command: [7:4] register address, [3:0] data nibble.
REQ-006 SHALL have port cmd_valid  input  1  cmd_byte present this cycle.
REQ-007 SHALL have port cmd_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port address  output  4  write address to color register file.
REQ-009 SHALL have port data  output  4  write data to color register file.
REQ-010 SHALL have port valid  output  1  write request, four-phase handshake.
REQ-011 SHALL have port ack  input  1  write acknowledge from register file.
REQ-012 SHALL have port busy  output  1  FIFO non-empty or handshake in progress.
REQ-013 SHALL have port err  output  1  sticky ack-timeout flag.
REQ-014 SHALL have port err_clr  input  1  clears err.

Function
REQ-015 SHALL push cmd_byte into FIFO on a cycle with cmd_valid=1 and cmd_ready=1; cmd_ready = (count < FIFO_DEPTH), registered-count based, no same-cycle pop bypass.
REQ-016 SHALL ignore cmd_valid when FIFO is full; byte dropped, no state change.
REQ-017 SHALL implement FSM IDLE, REQ, REL; reset state IDLE.
REQ-018 IDLE: FIFO non-empty -> pop head, register address/data, assert valid next cycle, go REQ (1 cycle from pop to valid).
REQ-019 REQ: hold valid=1, address, data stable until ack=1 sampled; then valid=0 next cycle, go REL.
REQ-020 REL: wait ack=0 sampled, then go IDLE; next word may issue the following cycle (min 1 IDLE cycle between valid pulses).
REQ-021 address/data SHALL hold last issued values outside REQ; change only on pop.
REQ-022 Simultaneous push and pop SHALL keep count unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-023 ack=1 in IDLE SHALL be ignored (no pop blocked, no error).
REQ-024 busy = (count != 0) or (state != IDLE).
REQ-025 err_clr=1 SHALL clear err; set takes priority if both occur the same cycle.

Reset
REQ-026 On rst=0 at a clock edge: state IDLE, FIFO empty (count 0, pointers 0), valid=0, address=0, data=0, err=0, timeout counter 0; cmd_ready=1 the cycle after.
REQ-027 Reset asserted mid-handshake SHALL drop valid the next edge and discard the in-flight word and FIFO contents.

Configuration
REQ-028 Macro COLOR_CFG_TIMEOUT_EN SHALL enable ack timeout logic.
REQ-029 With COLOR_CFG_TIMEOUT_EN: counter resets on entry to REQ/REL, increments each cycle in them; reaching TIMEOUT_CYCLES -> valid=0, err=1, state IDLE, word discarded.
REQ-030 Without COLOR_CFG_TIMEOUT_EN: no counter, FSM waits for ack indefinitely, err tied 0, err_clr ignored.

Verification
REQ-031 Push 0x35, ack responder 2-cycle delay -> valid high 1 cycle after pop, address=3, data=5, valid falls cycle after ack, one write total.
REQ-032 Push 5 bytes back-to-back with responder stalled, FIFO_DEPTH=4 -> cmd_ready=0 after 4th push (byte 5 dropped); later 4 writes in push order, no 5th.
REQ-033 Push 0xA1, 0xB2 with immediate ack -> two valid pulses separated by ≥1 low cycle, addresses A then B, busy falls after last REL.
REQ-034 rst=0 while valid=1 in REQ -> valid=0, busy=0, cmd_ready=1 after reset; no further writes.
REQ-035 COLOR_CFG_TIMEOUT_EN, TIMEOUT_CYCLES=8, ack held 0 -> valid drops after 8 REQ cycles, err=1 until err_clr pulse, next queued word issues normally.
REQ-036 Push and pop same cycle at count=2 -> count stays 2, order preserved across pointer wrap.
